// File: rtl/drone_pwm_pkg.sv
// rtl/drone_pwm_pkg.sv - shared duty-cycle constants and timebase helper for the ESC PWM block
package drone_pwm_pkg;

  localparam int                DUTY_W            = 8;
  localparam logic [DUTY_W-1:0] DUTY_MAX          = 8'd100;
  localparam logic [DUTY_W-1:0] DEFAULT_IDLE_DUTY = 8'd43;

  // Clock cycles per duty step; the caller keeps the division exact.
  function automatic int calc_step_cycles(input int clk_freq, input int pwm_freq, input int steps);
    return clk_freq / (pwm_freq * steps);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - step/percent counters, period boundary and period-start generation
module pwm_timebase
  import drone_pwm_pkg::*;
#(
  parameter int STEP_CYCLES = 10,
  parameter int STEPS       = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  output logic [DUTY_W-1:0] pct_next_o,
  output logic              boundary_o,
  output logic              period_start_o
);

  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int PCT_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [PCT_W-1:0]  PCT_LAST  = PCT_W'(STEPS - 1);

  logic [STEP_W-1:0] step_q, step_d;
  logic [PCT_W-1:0]  pct_q, pct_d;
  logic              run_q;
  logic              start_d;

  assign boundary_o = enable_i && run_q && (step_q == STEP_LAST) && (pct_q == PCT_LAST);

  // Next-cycle values are exported so the parent can register its outputs glitch-free.
  always_comb begin
    step_d  = '0;
    pct_d   = '0;
    start_d = 1'b0;
    if (enable_i) begin
      if (!run_q || boundary_o) begin
        start_d = 1'b1;
      end else if (step_q == STEP_LAST) begin
        pct_d = pct_q + 1'b1;
      end else begin
        step_d = step_q + 1'b1;
        pct_d  = pct_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
      pct_q  <= '0;
      run_q  <= 1'b0;
    end else begin
      step_q <= step_d;
      pct_q  <= pct_d;
      run_q  <= enable_i;
    end
  end

  assign pct_next_o     = DUTY_W'(pct_d);
  assign period_start_o = start_d;

endmodule

// File: rtl/esc_pwm_generator.sv
// rtl/esc_pwm_generator.sv - double-buffered ESC PWM output with command watchdog failsafe
module esc_pwm_generator
  import drone_pwm_pkg::*;
#(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int PWM_FREQ        = 50,
  parameter int STEPS           = int'(DUTY_MAX),
  parameter int IDLE_DUTY       = int'(DEFAULT_IDLE_DUTY),
  parameter int TIMEOUT_PERIODS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DUTY_W-1:0] duty_in,
  input  logic              duty_valid,
  output logic              pwm_out,
  output logic              period_start,
  output logic              duty_clamped,
  output logic              failsafe
);

  localparam int STEP_CYCLES = calc_step_cycles(CLK_FREQ, PWM_FREQ, STEPS);
  localparam int MISS_W      = $clog2(TIMEOUT_PERIODS + 1);
  localparam logic [DUTY_W-1:0] STEPS_L  = DUTY_W'(STEPS);
  localparam logic [DUTY_W-1:0] IDLE_L   = DUTY_W'(IDLE_DUTY);
  localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(TIMEOUT_PERIODS);

  logic [DUTY_W-1:0] pct_next;
  logic              boundary;
  logic              load;

  logic [DUTY_W-1:0] pending_q, pending_d;
  logic [DUTY_W-1:0] active_q, active_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              failsafe_q, failsafe_d;
  logic              seen_q, seen_d;
  logic              pwm_q, pwm_d;
  logic              start_q;
  logic              clamp_q, clamp_d;

  pwm_timebase #(
    .STEP_CYCLES (STEP_CYCLES),
    .STEPS       (STEPS)
  ) u_timebase (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable_i       (enable),
    .pct_next_o     (pct_next),
    .boundary_o     (boundary),
    .period_start_o (load)
  );

  always_comb begin
    pending_d  = pending_q;
    clamp_d    = 1'b0;
    seen_d     = seen_q | duty_valid;
    miss_d     = miss_q;
    failsafe_d = failsafe_q;
    active_d   = active_q;

    if (duty_valid) begin
      clamp_d   = (duty_in > STEPS_L);
      pending_d = clamp_d ? STEPS_L : duty_in;
    end

    // A valid on the boundary cycle itself counts for the period just ending.
    if (boundary) begin
      seen_d = 1'b0;
      if (seen_q || duty_valid) begin
        miss_d     = '0;
        failsafe_d = 1'b0;
      end else begin
        if (miss_q != MISS_MAX) miss_d = miss_q + 1'b1;
        if (miss_d == MISS_MAX) failsafe_d = 1'b1;
      end
    end

    if (load) active_d = failsafe_d ? IDLE_L : pending_d;
    pwm_d = enable && (pct_next < active_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= IDLE_L;
      active_q   <= IDLE_L;
      miss_q     <= '0;
      failsafe_q <= 1'b1;
      seen_q     <= 1'b0;
      pwm_q      <= 1'b0;
      start_q    <= 1'b0;
      clamp_q    <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      active_q   <= active_d;
      miss_q     <= miss_d;
      failsafe_q <= failsafe_d;
      seen_q     <= seen_d;
      pwm_q      <= pwm_d;
      start_q    <= load;
      clamp_q    <= clamp_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = start_q;
  assign duty_clamped = clamp_q;
  assign failsafe     = failsafe_q;

endmodule

// File: tb/tb_esc_pwm_generator.sv
// tb/tb_esc_pwm_generator.sv - self-checking bench for esc_pwm_generator against a cycle-phase reference model
module tb_esc_pwm_generator;

  localparam int STEPS       = 100;
  localparam int STEP_CYCLES = 10;
  localparam int PERIOD      = STEPS * STEP_CYCLES;
  localparam int TIMEOUT     = 3;
  localparam int IDLE        = 43;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] duty_in;
  logic       duty_valid;
  logic       pwm_out;
  logic       period_start;
  logic       duty_clamped;
  logic       failsafe;

  esc_pwm_generator #(
    .CLK_FREQ        (1000),
    .PWM_FREQ        (1),
    .STEPS           (STEPS),
    .IDLE_DUTY       (IDLE),
    .TIMEOUT_PERIODS (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .duty_clamped (duty_clamped),
    .failsafe     (failsafe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: tracks position inside the period in whole clock cycles.
  int m_pos, m_active, m_pending, m_miss;
  bit m_run, m_fail, m_seen, e_pwm, e_start, e_clamp;

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_active = IDLE; m_pending = IDLE;
    m_miss = 0; m_fail = 1; m_seen = 0;
    e_pwm = 0; e_start = 0; e_clamp = 0;
  endtask

  task automatic model_step(input bit en, input bit v, input int d);
    bit bnd;
    bnd = en && m_run && (m_pos == PERIOD - 1);
    e_clamp = v && (d > STEPS);
    if (v) m_pending = (d > STEPS) ? STEPS : d;
    if (bnd) begin
      if (m_seen || v) begin
        m_miss = 0;
        m_fail = 0;
      end else begin
        if (m_miss < TIMEOUT) m_miss++;
        if (m_miss == TIMEOUT) m_fail = 1;
      end
      m_seen = 0;
    end else begin
      m_seen = m_seen || v;
    end
    e_start = en && (!m_run || bnd);
    if (e_start) begin
      m_pos = 0;
      m_active = m_fail ? IDLE : m_pending;
    end else if (en) begin
      m_pos++;
    end
    e_pwm = en && (m_pos < m_active * STEP_CYCLES);
    m_run = en;
  endtask

  // Per-period observation of the DUT line.
  int hi_cnt = 0, len_cnt = 0, last_hi = 0, last_len = 0;

  task automatic tick();
    model_step(enable, duty_valid, int'(duty_in));
    @(negedge clk);
    check("outs{pwm,start,clamp,failsafe}",
          int'({pwm_out, period_start, duty_clamped, failsafe}),
          int'({e_pwm, e_start, e_clamp, m_fail}));
    if (period_start) begin
      last_hi = hi_cnt; last_len = len_cnt; hi_cnt = 0; len_cnt = 0;
    end
    len_cnt++;
    if (pwm_out) hi_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_starts(input int n, output int cyc);
    int seen;
    seen = 0; cyc = 0;
    while (seen < n && cyc < n * PERIOD + 20) begin
      tick();
      cyc++;
      if (period_start) seen++;
    end
    if (seen < n) check("period_start_timeout", seen, n);
  endtask

  task automatic send(input logic [7:0] d);
    duty_in = d; duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
  endtask

  task automatic period_check(input string tag, input int exp_hi);
    int cyc;
    wait_starts(1, cyc);
    check({tag, "_high"}, last_hi, exp_hi);
    check({tag, "_len"}, last_len, PERIOD);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; enable = 1'b0; duty_in = 8'd0; duty_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outs", int'({pwm_out, period_start, duty_clamped, failsafe}), 1);
    rst_n = 1'b1;
    ticks(3);

    // Test 1: idle duty with no commands
    enable = 1'b1;
    wait_starts(1, cyc);
    check("t1_first_start_latency", cyc, 1);
    period_check("t1_idle_p1", 430);
    period_check("t1_idle_p2", 430);
    check("t1_failsafe", int'(failsafe), 1);

    // Test 2: mid-period command applies next period
    ticks(300);
    send(8'h19);
    period_check("t2_unchanged", 430);
    check("t2_failsafe_cleared", int'(failsafe), 0);
    period_check("t2_duty25", 250);

    // Test 3: over-range duty clamps to 100 %
    ticks(100);
    duty_in = 8'hC8; duty_valid = 1'b1;
    tick();
    check("t3_clamp_pulse", int'(duty_clamped), 1);
    duty_valid = 1'b0;
    tick();
    check("t3_clamp_single", int'(duty_clamped), 0);
    period_check("t3_prev", 250);
    period_check("t3_full_p1", PERIOD);
    check("t3_high_at_boundary", int'(pwm_out), 1);
    period_check("t3_full_p2", PERIOD);

    // Test 4: watchdog timeout and recovery
    send(8'h32);
    period_check("t4_prev_full", PERIOD);
    period_check("t4_half_p1", 500);
    period_check("t4_half_p2", 500);
    period_check("t4_half_p3", 500);
    check("t4_failsafe_set", int'(failsafe), 1);
    period_check("t4_failsafe_idle", 430);
    ticks(200);
    send(8'h0A);
    period_check("t4_idle_unchanged", 430);
    check("t4_failsafe_clear", int'(failsafe), 0);
    period_check("t4_duty10", 100);

    // Test 5: zero duty, then command landing on the boundary cycle
    ticks(50);
    send(8'h00);
    period_check("t5_prev", 100);
    ticks(PERIOD - 1);
    send(8'h64);
    check("t5_boundary_start", int'(period_start), 1);
    check("t5_zero_high", last_hi, 0);
    check("t5_immediate_full", int'(pwm_out), 1);
    period_check("t5_full", PERIOD);

    // Test 6: enable drop and asynchronous reset
    send(8'h32);
    period_check("t6_prev_full", PERIOD);
    ticks(200);
    check("t6_high_before_drop", int'(pwm_out), 1);
    enable = 1'b0;
    tick();
    check("t6_low_after_drop", int'(pwm_out), 0);
    ticks(5);
    enable = 1'b1;
    tick();
    check("t6_restart_start", int'(period_start), 1);
    ticks(300);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_async_reset_outs", int'({pwm_out, period_start, duty_clamped, failsafe}), 1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_starts(1, cyc);
    check("t6_restart_latency", cyc, 1);
    period_check("t6_post_reset_idle", 430);

    // Randomized traffic against the reference model
    for (int i = 0; i < 16000; i++) begin
      int unsigned rate;
      rate = ((i / 4000) % 2 == 1) ? 3000 : 150;
      duty_valid = ($urandom_range(0, rate - 1) == 0);
      duty_in = 8'($urandom_range(0, 255));
      if (enable && $urandom_range(0, 2999) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 15) == 0) enable = 1'b1;
      tick();
    end
    duty_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
